// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment encoder/decoder pair.
// Holds the default digit count, segment bus width, the nibble/segment types
// and the common-anode code table. The display driver reads the same table,
// so encoder and decoder cannot drift apart.
package seg_pkg;

    localparam int NUM_DIGITS_DEFAULT = 6;
    localparam int SEG_W              = 8;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [3:0]       nibble_t;

    // Active-low common-anode codes for 0..F, with dp (bit7) held off (1).
    localparam seg_t SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational reverse lookup of a 7-bit active-low
// segment pattern (g..a) against SEG_CODE.
//   pat : segment bits 6:0 as seen on the bus (dp excluded)
//   nib : recovered hex value (0 when there is no hit)
//   hit : 1 when the pattern is one of the sixteen legal codes
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output nibble_t    nib,
    output logic       hit
);

    // The table entries are all distinct, so at most one entry matches.
    always_comb begin
        nib = '0;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (SEG_CODE[k][6:0] == pat) begin
                nib = nibble_t'(k);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors the active-low digit-select and segment nets of
// a seven-segment display and recovers the nibble and decimal point per
// digit. Works for static drive (all digits selected) and for multiplexed
// scanning (one digit selected at a time). A bus value is committed once it
// has been held for STABLE_CYCLES consecutive identical samples.
//   clk, rst    : clock, synchronous active-high reset
//   sel         : digit select, active-low, one bit per digit
//   seg_led     : segments, active-low; bit7 = dp, bits 6:0 = g..a
//   clr_err     : clears the sticky error flags (a same-edge error wins)
//   digits      : decoded nibbles, digit i at [4i+3:4i]
//   dp          : decimal point lit, per digit
//   digit_valid : last commit to digit i was a legal pattern
//   upd         : one-cycle pulse after every commit
//   err_sel     : sticky, an illegal select combination was committed
//   err_pat     : sticky, an unrecognised segment pattern was committed
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEFAULT,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   sel,
    input  logic [SEG_W-1:0]        seg_led,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic                    err_sel,
    output logic                    err_pat
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef struct packed {
        logic [NUM_DIGITS-1:0] sel;
        seg_t                  seg;
    } samp_t;

    samp_t                          samp_q, samp_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic                           committed_q, committed_d;
    logic [NUM_DIGITS-1:0][3:0]     digits_q, digits_d;
    logic [NUM_DIGITS-1:0]          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]          valid_q, valid_d;
    logic                           upd_q, upd_d;
    logic                           err_sel_q, err_sel_d;
    logic                           err_pat_q, err_pat_d;

    logic                           same, commit;
    logic [NUM_DIGITS-1:0]          low, apply_mask;
    logic                           bad_sel;
    nibble_t                        dec_nib;
    logic                           dec_hit;

    seg_pattern_decode u_dec (
        .pat (samp_q.seg[6:0]),
        .nib (dec_nib),
        .hit (dec_hit)
    );

    // Select classification: none low = blank, all low = static,
    // exactly one low = scan; anything else is an illegal combination.
    always_comb begin
        low        = ~samp_q.sel;
        apply_mask = '0;
        if ((&low) || $onehot(low)) apply_mask = low;
        bad_sel    = (|low) && !(&low) && !$onehot(low);
    end

    always_comb begin
        samp_d      = {sel, seg_led};
        same        = (samp_d == samp_q);
        cnt_d       = cnt_q;
        committed_d = committed_q;
        if (!same) begin
            cnt_d       = '0;
            committed_d = 1'b0;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Only the edge that brings the count to STABLE commits; the
        // committed flag stops a held value from committing again.
        commit = same && (cnt_d == STABLE) && !committed_q;
        if (commit) committed_d = 1'b1;

        digits_d  = digits_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        upd_d     = commit;
        err_sel_d = clr_err ? 1'b0 : err_sel_q;
        err_pat_d = clr_err ? 1'b0 : err_pat_q;

        if (commit) begin
            if (bad_sel) err_sel_d = 1'b1;
            if ((|apply_mask) && !dec_hit) err_pat_d = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (apply_mask[i]) begin
                    dp_d[i]    = ~samp_q.seg[7];
                    valid_d[i] = dec_hit;
                    if (dec_hit) digits_d[i] = dec_nib;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q      <= '{sel: '1, seg: '0};
            cnt_q       <= '0;
            committed_q <= 1'b1;
            digits_q    <= '0;
            dp_q        <= '0;
            valid_q     <= '0;
            upd_q       <= 1'b0;
            err_sel_q   <= 1'b0;
            err_pat_q   <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            upd_q       <= upd_d;
            err_sel_q   <= err_sel_d;
            err_pat_q   <= err_pat_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign upd         = upd_q;
    assign err_sel     = err_sel_q;
    assign err_pat     = err_pat_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed vectors, a behavioural model that
// commits a bus value when it has been seen on exactly STABLE_CYCLES+1
// consecutive edges (preceded by a different value), a per-cycle compare,
// and hand-computed literal expectations.
module tb_seg_scan_decoder;

    localparam int N = 6;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr_err = 1'b0;
    logic [N-1:0]   sel = '1;
    logic [7:0]     seg_led = 8'h00;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp, digit_valid;
    logic           upd, err_sel, err_pat;

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .seg_led     (seg_led),
        .clr_err     (clr_err),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .upd         (upd),
        .err_sel     (err_sel),
        .err_pat     (err_pat)
    );

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    int code_tab [16] = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'hF8,
                          'h80, 'h90, 'h88, 'h83, 'hC6, 'hA1, 'h86, 'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_dig [N];
    bit          m_dp [N];
    bit          m_val [N];
    bit          m_upd, m_es, m_ep;
    bit          started = 0;
    logic [13:0] hist [$];

    always @(posedge clk) begin
        logic [13:0] v;
        bit          c;
        int          nz, idx, nib;
        if (rst) begin
            hist = {};
            hist.push_back({{N{1'b1}}, 8'h00});
            for (int i = 0; i < N; i++) begin
                m_dig[i] = 0; m_dp[i] = 0; m_val[i] = 0;
            end
            m_upd = 0; m_es = 0; m_ep = 0;
            started = 1;
        end else if (started) begin
            v = {sel, seg_led};
            hist.push_back(v);
            if (hist.size() > S + 2) void'(hist.pop_front());
            c = (hist.size() == S + 2) && (hist[0] != v);
            for (int k = 1; k < hist.size(); k++) if (hist[k] != v) c = 0;
            if (clr_err) begin m_es = 0; m_ep = 0; end
            m_upd = c;
            if (c) begin
                nz = 0; idx = 0;
                for (int i = 0; i < N; i++) if (!v[8+i]) begin nz++; idx = i; end
                nib = -1;
                for (int k = 0; k < 16; k++) if ((code_tab[k] & 'h7F) == int'(v[6:0])) nib = k;
                if (nz != 0 && nz != 1 && nz != N) m_es = 1;
                else if (nz != 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (nz == N || i == idx) begin
                            m_dp[i] = !v[7];
                            if (nib >= 0) begin m_dig[i] = nib; m_val[i] = 1; end
                            else begin m_val[i] = 0; m_ep = 1; end
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [4*N-1:0] ed;
        logic [N-1:0]   edp, evl;
        if (upd === 1'b1) upd_cnt++;
        if (started) begin
            for (int i = 0; i < N; i++) begin
                ed[4*i +: 4] = 4'(m_dig[i]);
                edp[i] = m_dp[i];
                evl[i] = m_val[i];
            end
            chk("cyc_digits", 32'(digits), 32'(ed));
            chk("cyc_dp", 32'(dp), 32'(edp));
            chk("cyc_valid", 32'(digit_valid), 32'(evl));
            chk("cyc_upd", 32'(upd), 32'(m_upd));
            chk("cyc_err_sel", 32'(err_sel), 32'(m_es));
            chk("cyc_err_pat", 32'(err_pat), 32'(m_ep));
        end
    end

    task automatic hold(input logic [N-1:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg_led = g;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int u0;
        // Reset with a static pattern already on the bus.
        sel = '0; seg_led = 8'hA4; rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_valid", 32'(digit_valid), 0);
        chk("rst_dp", 32'(dp), 0);
        chk("rst_flags", {29'd0, upd, err_sel, err_pat}, 0);
        rst = 1'b0;
        u0 = upd_cnt;
        repeat (6) @(negedge clk);
        chk("static_digits", 32'(digits), 32'h222222);
        chk("static_valid", 32'(digit_valid), 32'h3F);
        chk("static_upd", upd_cnt - u0, 1);

        // Scanning, one digit at a time.
        u0 = upd_cnt;
        hold(6'b111110, 8'hF9, 6);
        hold(6'b111101, 8'hB0, 6);
        hold(6'b011111, 8'h8E, 6);
        chk("scan_digits", 32'(digits), 32'hF22231);
        chk("scan_upd", upd_cnt - u0, 3);

        // Glitch mid-count restarts the run; the glitch value never commits.
        u0 = upd_cnt;
        hold(6'b111011, 8'h99, 3);
        hold(6'b111011, 8'h92, 1);
        hold(6'b111011, 8'h99, 6);
        chk("glitch_digits", 32'(digits), 32'hF22431);
        chk("glitch_upd", upd_cnt - u0, 1);

        // Unrecognised pattern with dp lit.
        hold(6'b111110, 8'h7F, 6);
        chk("badpat_digits", 32'(digits), 32'hF22431);
        chk("badpat_valid", 32'(digit_valid), 32'h3E);
        chk("badpat_dp", 32'(dp), 32'h01);
        chk("badpat_err", 32'(err_pat), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err_pat", 32'(err_pat), 0);

        // Illegal select, then blank.
        u0 = upd_cnt;
        hold(6'b111100, 8'hC0, 6);
        chk("illsel_err", 32'(err_sel), 1);
        chk("illsel_digits", 32'(digits), 32'hF22431);
        chk("illsel_upd", upd_cnt - u0, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err_sel", 32'(err_sel), 0);
        u0 = upd_cnt;
        hold(6'b111111, 8'hC0, 6);
        chk("blank_upd", upd_cnt - u0, 1);
        chk("blank_digits", 32'(digits), 32'hF22431);

        // clr_err on the commit edge of an illegal select: error wins.
        hold(6'b111100, 8'hC0, 4);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("coincide_err_sel", 32'(err_sel), 1);
        repeat (2) @(negedge clk);

        // Reset while the count sits at 3: nothing commits.
        hold(6'b000000, 8'hC0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_digits", 32'(digits), 0);
        chk("midrst_misc", {dp, digit_valid, upd, err_sel, err_pat}, 0);
        sel = '1; seg_led = 8'h00;
        rst = 1'b0;
        u0 = upd_cnt;
        repeat (8) @(negedge clk);
        chk("idle_upd", upd_cnt - u0, 0);
        chk("idle_digits", 32'(digits), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the seven-segment display drivers: it samples the active-low digit-select and segment buses that drive the board display and recovers the hex nibble and decimal point per digit. It handles both static drive (all digits selected) and multiplexed scanning (one digit selected at a time). Uses: display loopback checking on hardware, and a monitor in FPGA self-test. Sits beside the display driver, fed by the same sel/seg_led nets.

Parameters:
NUM_DIGITS, 6, number of digit positions (sel width)
STABLE_CYCLES, 4, consecutive identical samples required before commit (legal range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sel  in  NUM_DIGITS  digit select, active-low (bit i low = digit i enabled)
seg_led  in  8  segments, active-low; bit7 = dp, bits 6:0 = g..a
clr_err  in  1  synchronous clear of sticky error flags
digits  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
dp  out  NUM_DIGITS  decimal point on (1 = lit)
digit_valid  out  NUM_DIGITS  1 = last commit for digit i was a legal pattern
upd  out  1  one-cycle pulse on any commit
err_sel  out  1  sticky: illegal select combination committed
err_pat  out  1  sticky: unrecognised segment pattern committed

Behaviour:
- Reset (rst=1 at an edge): digits=0, dp=0, digit_valid=0, upd=0, err_sel=0, err_pat=0, sample reg={sel all 1, seg 0x00}, cnt=0, committed=1. Reset overrides everything, including a commit in flight.
- Input stage: {sel,seg_led} registered into samp every edge (no synchroniser; inputs are same-clock).
- Stability: if the incoming value != samp: cnt<=0, committed<=0. Else cnt increments, saturating at STABLE_CYCLES. On the edge where cnt becomes STABLE_CYCLES and committed=0: perform commit, set committed=1. A value held indefinitely commits exactly once.
- Latency: new value first sampled on edge 0 and held; commit registers on edge STABLE_CYCLES; upd is high for the following cycle only.
- Commit classification by samp.sel:
  - all 1 (blank): upd pulses; no digit or flag changes.
  - all 0 (static): pattern applied to all digits.
  - exactly one bit i low (scan): pattern applied to digit i only.
  - any other: err_sel<=1, upd pulses, no digit changes.
- Pattern decode uses seg bits 6:0, common-anode table 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (bit7 masked to 1 for lookup). Hit: digits[i]<=nibble, digit_valid[i]<=1. Miss: digits[i] holds its value, digit_valid[i]<=0, err_pat<=1. dp[i] <= ~seg_led[7] in both cases.
- clr_err=1 clears both sticky flags. If clr_err and a new error coincide on the same edge, the error wins (flag set).
- A change of input mid-count restarts the count. Partial runs never commit.

Decomposition:
- seg_pkg: NUM_DIGITS default, SEG_W=8, typedefs seg_t (logic[7:0]) and nibble_t (logic[3:0]), constant array SEG_CODE[16] holding the encoding above. The display driver uses the same array so encoder and decoder cannot diverge.
- Sub-module seg_pattern_decode: combinational, 7-bit pattern in, nibble_t plus hit out, searches SEG_CODE. Instantiated once; the select decode fans the result out.

Test Plan:
- Reset: assert rst 2 cycles with sel=000000, seg=0xA4 -> all outputs 0. After release and 4 cycles held: digits=0x222222, digit_valid=0x3F, upd pulses once.
- Scan: drive sel=111110/seg=0xF9, then 111101/0xB0, then 011111/0x8E, each held 6 cycles -> digits[3:0]=1, digits[7:4]=3, digits[23:20]=F. 3 upd pulses, each exactly 4 edges after its value is first sampled.
- Glitch rejection: hold sel=111011/seg=0x99 for 3 cycles, then 1 cycle of 0x92, then 0x99 held -> no commit until 4 stable cycles after the glitch. digits[11:8]=4. No 5 ever committed.
- Bad pattern/dp: sel=111110, seg=0x7F held -> digit 0 keeps its prior value, digit_valid[0]=0, dp[0]=1, err_pat=1. Pulse clr_err -> err_pat=0.
- Illegal select: sel=111100 held, seg=0xC0 -> err_sel=1, digits unchanged, upd pulses once. sel=111111 held -> upd pulses, no changes.
- Simultaneous events: clr_err asserted on the commit edge of an illegal select -> err_sel=1. rst asserted at cnt=3 -> no commit, all outputs 0.
